uart_msg_tx: RTL and testbench

//   Parametrised UART message transmitter. A debounced rising edge on btn sends a

---
 rtl/uart_msg_tx_if.sv | 10 +
 rtl/uart_msg_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_msg_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_tx_if.sv
// rtl/uart_msg_tx_if.sv - button input and UART line bundle for uart_msg_tx
interface uart_msg_tx_if;
    logic btn;
    logic tx;
    logic busy;
    logic done;

    modport master (output btn, input tx, input busy, input done);
    modport slave  (input btn, output tx, output busy, output done);
endinterface

// File: rtl/uart_msg_tx.sv
// rtl/uart_msg_tx.sv - debounced button triggers a fixed multi-byte UART message
module uart_msg_tx #(
    parameter int                   CLKS_PER_BIT = 104,
    parameter int                   MSG_LEN      = 3,
    parameter logic [8*MSG_LEN-1:0] MSG          = "Hi\n",
    parameter int                   PARITY       = 0,
    parameter int                   STOP_BITS    = 1,
    parameter int                   DEBOUNCE     = 120000
) (
    input  logic         hwclk,
    input  logic         rst,
    uart_msg_tx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [BW-1:0] BYTE_LAST  = BW'(MSG_LEN - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);
    localparam logic          HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            btn_s1;
    logic            btn_s2;
    logic            deb_level;
    logic            deb_prev;
    logic [DW-1:0]   deb_cnt;
    logic            trigger;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic            stop_idx;
    logic [BW-1:0]   byte_idx;
    logic [7:0]      cur_byte;
    logic            par_bit;
    logic            bit_end;
    logic            last_stop;
    logic            last_byte;
    logic            tx_c;
    logic            busy_c;
    logic            done_c;

    // Synchronise the button, then accept a new level only after a stable run
    always_ff @(posedge hwclk) begin
        if (rst) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_s1   <= bus.btn;
            btn_s2   <= btn_s1;
            deb_prev <= deb_level;
            if (btn_s2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= btn_s2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign trigger   = deb_level & ~deb_prev;
    assign bit_end   = (bit_cnt == BIT_LAST);
    assign last_stop = (stop_idx == STOP_LAST);
    assign last_byte = (byte_idx == BYTE_LAST);

    // Pick the current message byte; byte 0 is the leftmost character
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (byte_idx == BW'(i)) begin
                cur_byte = MSG[8*(MSG_LEN-1-i) +: 8];
            end
        end
    end

    assign par_bit = (PARITY == 1) ? ~^cur_byte : ^cur_byte;

    // FSM state register
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Bit timing, data bit, stop bit and byte counters
    always_ff @(posedge hwclk) begin
        if (rst) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            byte_idx <= '0;
        end else begin
            if (state == S_IDLE || state == S_DONE || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (state != S_STOP) begin
                stop_idx <= 1'b0;
            end else if (bit_end) begin
                stop_idx <= stop_idx + 1'b1;
            end

            if (state == S_IDLE || state == S_DONE) begin
                byte_idx <= '0;
            end else if (state == S_STOP && bit_end && last_stop && !last_byte) begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    // Next state and line outputs; done shares its cycle with a possible restart
    always_comb begin
        state_n = state;
        tx_c    = 1'b1;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) state_n = S_START;
            end
            S_START: begin
                tx_c   = 1'b0;
                busy_c = 1'b1;
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                tx_c   = cur_byte[bit_idx];
                busy_c = 1'b1;
                if (bit_end && bit_idx == 3'd7) state_n = HAS_PARITY ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_c   = par_bit;
                busy_c = 1'b1;
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                busy_c = 1'b1;
                if (bit_end && last_stop) state_n = last_byte ? S_DONE : S_START;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_n = trigger ? S_START : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.tx   = tx_c;
    assign bus.busy = busy_c;
    assign bus.done = done_c;
endmodule

// File: tb/tb_uart_msg_tx.sv
// tb/tb_uart_msg_tx.sv - scoreboard bench for uart_msg_tx
module tb_uart_msg_tx;
    localparam int CPB = 4;

    typedef struct packed {
        logic [7:0] b;
        logic       p;
    } exp_t;

    logic hwclk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] busy_q;
    int   msg_cnt[3];
    int   done_cnt[3];

    uart_msg_tx_if b0();
    uart_msg_tx_if b1();
    uart_msg_tx_if b2();

    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(2), .MSG(16'h4869), .PARITY(0),
                  .STOP_BITS(1), .DEBOUNCE(8)) dut0 (.hwclk(hwclk), .rst(rst), .bus(b0));
    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(2), .MSG(16'h4869), .PARITY(2),
                  .STOP_BITS(2), .DEBOUNCE(8)) dut1 (.hwclk(hwclk), .rst(rst), .bus(b1));
    uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(2), .MSG(16'h4869), .PARITY(1),
                  .STOP_BITS(1), .DEBOUNCE(8)) dut2 (.hwclk(hwclk), .rst(rst), .bus(b2));

    assign tx_v[0]   = b0.tx;
    assign tx_v[1]   = b1.tx;
    assign tx_v[2]   = b2.tx;
    assign busy_v[0] = b0.busy;
    assign busy_v[1] = b1.busy;
    assign busy_v[2] = b2.busy;
    assign done_v[0] = b0.done;
    assign done_v[1] = b1.done;
    assign done_v[2] = b2.done;

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cyc <= cyc + 1;

    always @(negedge hwclk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_v[i] === 1'b1 && busy_q[i] !== 1'b1) msg_cnt[i] = msg_cnt[i] + 1;
            if (done_v[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
        end
        busy_q = busy_v;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic push(input int w, input logic [7:0] b, input logic p);
        exp_t e;
        e.b = b;
        e.p = p;
        case (w)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int w);
        case (w)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int w);
        case (w)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic wait_fall(input int w, input string nm, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge hwclk);
            if (tx_v[w] === 1'b0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({nm, "_fall_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input int w, input string nm, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge hwclk);
            if (done_v[w] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic monitor(input int w, input int par, input int stops);
        logic       smp[48];
        logic [7:0] data;
        logic       hold_ok;
        logic       stop_ok;
        logic       aborted;
        exp_t       e;
        int         nb;
        int         hp;
        hp = (par != 0) ? 1 : 0;
        nb = 1 + 8 + hp + stops;
        forever begin
            @(negedge hwclk);
            if (rst !== 1'b1 && tx_v[w] === 1'b0) begin
                aborted = 1'b0;
                smp[0]  = 1'b0;
                for (int i = 1; i < nb * CPB; i++) begin
                    @(negedge hwclk);
                    if (rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = tx_v[w];
                end
                if (!aborted) begin
                    hold_ok = 1'b1;
                    for (int k = 0; k < nb; k++)
                        for (int j = 1; j < CPB; j++)
                            if (smp[k*CPB+j] !== smp[k*CPB]) hold_ok = 1'b0;
                    for (int k = 0; k < 8; k++) data[k] = smp[(k+1)*CPB];
                    stop_ok = 1'b1;
                    for (int s = 0; s < stops; s++)
                        if (smp[(9+hp+s)*CPB] !== 1'b1) stop_ok = 1'b0;
                    if (q_size(w) == 0) begin
                        chk($sformatf("dut%0d_frame_expected", w), 0, 1);
                    end else begin
                        e = pop_exp(w);
                        chk($sformatf("dut%0d_byte", w), 32'(data), 32'(e.b));
                        chk($sformatf("dut%0d_bit_hold", w), 32'(hold_ok), 1);
                        chk($sformatf("dut%0d_stop", w), 32'(stop_ok), 1);
                        if (par != 0) chk($sformatf("dut%0d_parity", w), 32'(smp[9*CPB]), 32'(e.p));
                    end
                end
            end
        end
    endtask

    initial monitor(0, 0, 1);
    initial monitor(1, 2, 2);
    initial monitor(2, 1, 1);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int f;
        int f2;
        int d;
        int d2;
        int m0;
        int dc0;
        rst = 1'b1;
        b0.btn = 1'b0;
        b1.btn = 1'b0;
        b2.btn = 1'b0;
        step(3);
        chk("reset_tx", 32'(tx_v[0]), 1);
        chk("reset_busy", 32'(busy_v[0]), 0);
        chk("reset_done", 32'(done_v[0]), 0);
        rst = 1'b0;
        step(200);
        chk("idle_msgs", msg_cnt[0], 0);
        chk("idle_done", done_cnt[0], 0);
        chk("idle_tx", 32'(tx_v[0]), 1);

        // Clean press held past the end of the message
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        m0 = msg_cnt[0];
        dc0 = done_cnt[0];
        b0.btn = 1'b1;
        p = cyc;
        wait_fall(0, "clean", f);
        chk("clean_latency", f - p, 11);
        chk("clean_busy", 32'(busy_v[0]), 1);
        wait_done(0, "clean", d);
        chk("clean_len", d - f, 80);
        chk("done_busy", 32'(busy_v[0]), 0);
        chk("done_tx", 32'(tx_v[0]), 1);
        step(30);
        b0.btn = 1'b0;
        step(40);
        chk("held_msgs", msg_cnt[0] - m0, 1);
        chk("held_done", done_cnt[0] - dc0, 1);

        // Parity and stop-bit variants
        push(1, 8'h48, 1'b0);
        push(1, 8'h69, 1'b0);
        push(2, 8'h48, 1'b1);
        push(2, 8'h69, 1'b1);
        b1.btn = 1'b1;
        b2.btn = 1'b1;
        p = cyc;
        wait_fall(1, "even", f);
        chk("even_latency", f - p, 11);
        wait_done(2, "odd", d2);
        chk("odd_len", d2 - f, 88);
        wait_done(1, "even", d);
        chk("even_stop2_len", d - f, 96);
        b1.btn = 1'b0;
        b2.btn = 1'b0;
        step(20);

        // Short pulse and bouncing must not trigger
        m0 = msg_cnt[0];
        b0.btn = 1'b1;
        step(5);
        b0.btn = 1'b0;
        step(10);
        for (int i = 0; i < 10; i++) begin
            b0.btn = ~b0.btn;
            step(3);
        end
        b0.btn = 1'b0;
        step(30);
        chk("glitch_msgs", msg_cnt[0] - m0, 0);
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        b0.btn = 1'b1;
        wait_fall(0, "after_glitch", f);
        step(10);
        b0.btn = 1'b0;
        wait_done(0, "after_glitch", d);
        chk("after_glitch_len", d - f, 80);
        step(20);
        chk("after_glitch_msgs", msg_cnt[0] - m0, 1);

        // Second press during byte 1 is dropped
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        m0 = msg_cnt[0];
        b0.btn = 1'b1;
        wait_fall(0, "busy_press", f);
        step(10);
        b0.btn = 1'b0;
        while (cyc < f + 42) step(1);
        b0.btn = 1'b1;
        step(20);
        b0.btn = 1'b0;
        wait_done(0, "busy_press", d);
        chk("busy_press_len", d - f, 80);
        step(60);
        chk("busy_press_msgs", msg_cnt[0] - m0, 1);

        // Trigger lands in the done cycle
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        m0 = msg_cnt[0];
        b0.btn = 1'b1;
        p = cyc;
        step(20);
        b0.btn = 1'b0;
        while (cyc < p + 81) step(1);
        b0.btn = 1'b1;
        wait_done(0, "donecyc", d);
        chk("donecyc_done_at", d - p, 91);
        wait_fall(0, "donecyc_restart", f2);
        chk("donecyc_restart_gap", f2 - d, 1);
        step(10);
        b0.btn = 1'b0;
        wait_done(0, "donecyc_second", d2);
        chk("donecyc_second_len", d2 - f2, 80);
        step(30);
        chk("donecyc_msgs", msg_cnt[0] - m0, 2);

        // Reset during byte 0 data bit 3 aborts the message
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        b0.btn = 1'b1;
        wait_fall(0, "rst_mid", f);
        step(1);
        b0.btn = 1'b0;
        while (cyc < f + 17) step(1);
        chk("pre_rst_busy", 32'(busy_v[0]), 1);
        rst = 1'b1;
        dc0 = done_cnt[0];
        step(1);
        chk("rst_mid_tx", 32'(tx_v[0]), 1);
        chk("rst_mid_busy", 32'(busy_v[0]), 0);
        rst = 1'b0;
        q0.delete();
        step(60);
        chk("rst_mid_no_done", done_cnt[0] - dc0, 0);
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        m0 = msg_cnt[0];
        b0.btn = 1'b1;
        p = cyc;
        wait_fall(0, "post_rst", f);
        chk("post_rst_latency", f - p, 11);
        step(5);
        b0.btn = 1'b0;
        wait_done(0, "post_rst", d);
        chk("post_rst_len", d - f, 80);
        step(20);
        chk("post_rst_msgs", msg_cnt[0] - m0, 1);

        step(10);
        chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
